// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: MIO bus controller behind the multi-cycle CPU.
// Decodes RAM / GPIO / COUNTER / NULL space and runs each access with wait states.
//
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   CPU_MIO, mem_w        bus request (held until MIO_ready) and write flag
//   addr_in, wdata_in     byte address and write data from the CPU
//   Data_in, MIO_ready    registered read data and one-cycle completion strobe
//   ram_addr, ram_din     synchronous RAM word address and write data
//   ram_we, ram_dout      RAM write pulse and read data (1-cycle latency)
//   sw_in, led_out        switch inputs and LED register
//
// Build option: define MIO_COUNTER_EN to include the free-running counter
// at 32'hF000_0004; without it that address decodes as NULL space.

module mio_bus_ctrl #(
    parameter int unsigned RAM_WAIT = 2,
    parameter int unsigned RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RG_RAM  = 2'd0,
        RG_GPIO = 2'd1,
        RG_CNT  = 2'd2,
        RG_NULL = 2'd3
    } region_t;

    localparam logic [3:0] RAM_WAIT_LD = 4'(RAM_WAIT);

    state_t            state_q;
    state_t            state_d;
    region_t           region_d;
    region_t           region_q;
    logic [RAM_AW-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              first_q;
    logic [3:0]        cnt_q;
    logic [31:0]       data_q;
    logic [15:0]       led_q;
    logic [31:0]       rd_data;
    logic [31:0]       cnt_val;
    logic              load;
    logic              exit_acc;
    logic              ready;

    // Address decode on the live request; only used when latching in IDLE.
    always_comb begin
        region_d = RG_NULL;
        unique case (1'b1)
            (addr_in[31:28] != 4'hF):   region_d = RG_RAM;
            (addr_in == 32'hF000_0000): region_d = RG_GPIO;
`ifdef MIO_COUNTER_EN
            (addr_in == 32'hF000_0004): region_d = RG_CNT;
`endif
            default:                    region_d = RG_NULL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        exit_acc = 1'b0;
        ready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (CPU_MIO) begin
                    load    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    exit_acc = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request is captured once in IDLE; later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            region_q <= RG_NULL;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else if (load) begin
            region_q <= region_d;
            waddr_q  <= addr_in[RAM_AW+1:2];
            wdata_q  <= wdata_in;
            we_q     <= mem_w;
        end
    end

    // first_q marks the first ACCESS cycle so ram_we pulses exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            first_q <= load;
            if (load) begin
                cnt_q <= (region_d == RG_RAM) ? RAM_WAIT_LD : 4'd0;
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

`ifdef MIO_COUNTER_EN
    logic [31:0] counter_q;
    logic        cnt_wr;

    assign cnt_wr = exit_acc && we_q && (region_q == RG_CNT);

    // A CPU write wins over the increment in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= 32'h0;
        end else if (cnt_wr) begin
            counter_q <= wdata_q;
        end else begin
            counter_q <= counter_q + 32'd1;
        end
    end

    assign cnt_val = counter_q;
`else
    assign cnt_val = 32'h0;
`endif

    always_comb begin
        rd_data = 32'h0;
        unique case (region_q)
            RG_RAM:  rd_data = ram_dout;
            RG_GPIO: rd_data = {16'h0, sw_in};
            RG_CNT:  rd_data = cnt_val;
            default: rd_data = 32'h0;
        endcase
    end

    // Data_in only moves on a completed read; writes leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= 32'h0;
        end else if (exit_acc && !we_q) begin
            data_q <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= 16'h0;
        end else if (exit_acc && we_q && region_q == RG_GPIO) begin
            led_q <= wdata_q[15:0];
        end
    end

    assign Data_in   = data_q;
    assign MIO_ready = ready;
    assign ram_addr  = waddr_q;
    assign ram_din   = wdata_q;
    assign ram_we    = (state_q == ACCESS) && first_q && we_q
                       && (region_q == RG_RAM);
    assign led_out   = led_q;

endmodule
